// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and counter sizing for the sequential divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration producing a single quotient bit
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nrem,
  output logic             qbit
);
  logic [WIDTH:0] sh, trial;
  // Shift in the next dividend bit, try the subtraction, restore when it goes negative
  always_comb begin
    sh = {prem, in_bit};
    trial = sh - {1'b0, divisor};
    qbit = ~trial[WIDTH];
    nrem = qbit ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle restoring divider, one quotient bit per clock (optional SIGNED_DIV_EN)
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
  div_state_e state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] prem, nrem, dq, dsr, a_mag, b_mag, q_nxt, q_fix, r_fix;
  logic qbit, neg_q, neg_r;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
`ifdef SIGNED_DIV_EN
  logic sq, sr;
  // The core only sees magnitudes; signs are reapplied when the result is loaded
  always_comb begin
    a_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    b_mag = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
  end
  // Capture the result signs together with the operands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sq, sr} <= 2'b00;
    else if (in_valid && in_ready) {sq, sr} <= {is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]), is_signed && dividend[WIDTH-1]};
  assign neg_q = sq;
  assign neg_r = sr;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign neg_q = 1'b0;
  assign neg_r = 1'b0;
`endif
  div_step #(.WIDTH(WIDTH)) u_step (
    .prem(prem), .in_bit(dq[WIDTH-1]), .divisor(dsr), .nrem(nrem), .qbit(qbit)
  );
  assign q_nxt = {dq[WIDTH-2:0], qbit};
  assign q_fix = neg_q ? -q_nxt : q_nxt;
  assign r_fix = neg_r ? -nrem : nrem;
  // dq shifts dividend bits out of the top while quotient bits enter at the bottom
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      prem <= '0;
      dq <= '0;
      dsr <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid && divisor == '0) begin
        quotient <= '1;
        remainder <= dividend;
        div_by_zero <= 1'b1;
        state <= DONE;
      end else if (in_valid) begin
        dq <= a_mag;
        dsr <= b_mag;
        prem <= '0;
        cnt <= CW'(WIDTH - 1);
        state <= CALC;
      end
    end else if (state == CALC) begin
      prem <= nrem;
      dq <= q_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        quotient <= q_fix;
        remainder <= r_fix;
        div_by_zero <= 1'b0;
        state <= DONE;
      end
    end else if (out_ready) state <= IDLE;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and model-checked bench for the 8-bit divider
module tb_seq_restoring_divider;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, div_by_zero;
  logic [7:0] dividend = 0, divisor = 0, quotient, remainder;
`ifdef SIGNED_DIV_EN
  logic is_signed = 0;
`endif
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
`ifdef SIGNED_DIV_EN
    .is_signed(is_signed),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic sg, output int lat);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    dividend = a;
    divisor = b;
`ifdef SIGNED_DIV_EN
    is_signed = sg;
`endif
    in_valid = 1;
    lat = 0;
    do begin
      @(posedge clk);
      #1 in_valid = 0;
      lat++;
    end while (!out_valid && lat < 40);
  endtask
  task automatic release_out();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("in_ready_after_hs", in_ready, 1);
  endtask
  task automatic div(input logic [7:0] a, input logic [7:0] b, input logic sg,
                     input logic [7:0] eq, input logic [7:0] er, input logic ez, input int elat);
    int lat;
    launch(a, b, sg, lat);
    chk("out_valid", out_valid, 1);
    if (elat > 0) chk("latency", lat, elat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
    release_out();
  endtask
  initial begin
    int lat;
    logic seen;
    logic [7:0] a, b;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    #20 rst_n = 1;
    div(200, 7, 0, 28, 4, 0, 9);
    div(13, 0, 0, 8'hFF, 13, 1, 1);
    div(5, 9, 0, 0, 5, 0, 9);
    div(255, 1, 0, 255, 0, 0, 9);
    div(255, 255, 0, 1, 0, 0, 9);
    launch(200, 7, 0, lat);
    chk("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_quotient", quotient, 28);
      chk("bp_remainder", remainder, 4);
    end
    release_out();
    @(negedge clk);
    dividend = 100;
    divisor = 3;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    chk("calc_in_ready", in_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_quotient", quotient, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("midrst_no_pulse", seen, 0);
    div(100, 3, 0, 33, 1, 0, 9);
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      div(a, b, 0, a / b, a % b, 0, 9);
    end
`ifdef SIGNED_DIV_EN
    div(8'hF9, 8'h02, 1, 8'hFD, 8'hFF, 0, 9);
    div(8'h80, 8'hFF, 1, 8'h80, 8'h00, 0, 9);
    div(8'h07, 8'hFE, 1, 8'hFD, 8'h01, 0, 9);
    div(8'hF9, 8'h00, 1, 8'hFF, 8'hF9, 1, 1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
